// File: rtl/regfile_bypass_sb.sv
// Parametrised integer register file: one write port, NUM_READ combinational read
// ports with optional write-to-read bypass, and a per-register busy scoreboard.
module regfile_bypass_sb #(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 32,
    parameter int          NUM_READ = 2,
    parameter int          SP_INDEX = 29,
    parameter logic [31:0] SP_INIT  = 32'h00000800,
    parameter bit          BYPASS   = 1'b1,
    localparam int         ADDR_W   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         rsv_en,
    input  logic [ADDR_W-1:0]            rsv_addr,
    input  logic [NUM_READ*ADDR_W-1:0]   raddr,
    output logic [NUM_READ*DATA_W-1:0]   rdata,
    output logic [NUM_READ-1:0]          rbusy,
    output logic [ADDR_W:0]              busy_cnt
);

    localparam logic [DATA_W-1:0] SP_INIT_W = DATA_W'(SP_INIT);

    // Register 0 is hardwired to zero, so storage starts at index 1.
    logic [DATA_W-1:0] regs_reg [1:DEPTH-1];
    logic [DEPTH-1:1]  busy_reg;
    logic [DEPTH-1:1]  busy_next;
    logic [ADDR_W:0]   busy_cnt_reg;
    logic [ADDR_W:0]   busy_cnt_next;
    logic [DEPTH-1:0]  busy_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < DEPTH; r++) begin
                regs_reg[r] <= (r == SP_INDEX) ? SP_INIT_W : '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_reg[waddr] <= wdata;
        end
    end

    // A new reservation wins over a release of the same register: the new producer owns it.
    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_busy
            always_comb begin
                busy_next[gi] = busy_reg[gi];
                if (rsv_en && (rsv_addr == ADDR_W'(gi))) begin
                    busy_next[gi] = 1'b1;
                end else if (we && (waddr == ADDR_W'(gi))) begin
                    busy_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        busy_cnt_next = '0;
        for (int r = 1; r < DEPTH; r++) begin
            busy_cnt_next = busy_cnt_next + (ADDR_W+1)'(busy_next[r]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_full = {busy_reg, 1'b0};
    assign busy_cnt  = busy_cnt_reg;

    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_read
            logic [ADDR_W-1:0] ra;
            logic              wr_hit;
            assign ra     = raddr[gi*ADDR_W +: ADDR_W];
            assign wr_hit = BYPASS && we && (waddr == ra);

            assign rdata[gi*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                                wr_hit     ? wdata :
                                                             regs_reg[ra];
            // A bypassed value is final, so the matching reader need not stall.
            assign rbusy[gi] = busy_full[ra] && !wr_hit;
        end
    endgenerate

endmodule
